pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- pipeline register between two handshaked stages, carrying a
// control bundle and a payload.
//
// Build option: macro PIPE_SKID_REG_SKID_EN
//   defined   : two-entry skid buffer (states EMPTY/ONE/TWO). in_ready is a
//               register, so there is no combinational path from out_ready.
//   undefined : single register (states EMPTY/ONE). in_ready is
//               (!out_valid || out_ready) && !reset.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous squash of every held entry; has priority over transfers
//   in_valid   upstream offers an entry
//   in_ready   block accepts an entry this cycle
//   in_ctrl    upstream control bundle (CTRL_W bits)
//   in_data    upstream payload (DATA_W bits)
//   out_valid  head entry valid
//   out_ready  downstream takes the head entry this cycle
//   out_ctrl   head control bundle, forced to zero while out_valid=0
//   out_data   head payload (holds its last value when empty)
//   stall_cnt  saturating count of edges with out_valid=1 and out_ready=0
module pipe_skid_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 127,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_SKID_REG_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

  state_t              state_reg;
  state_t              state_next;
  logic [CTRL_W-1:0]   main_ctrl_reg;
  logic [DATA_W-1:0]   main_data_reg;
  logic [CNT_W-1:0]    stall_cnt_reg;
  logic                in_xfer;
  logic                out_xfer;
  logic                load_main_in;

  assign out_valid = (state_reg != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Control bundle is gated so an empty stage never presents live control bits,
  // even though the main register keeps its stale contents after a flush.
  assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
  assign out_data  = main_data_reg;
  assign stall_cnt = stall_cnt_reg;

`ifdef PIPE_SKID_REG_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic              in_ready_reg;
  logic              load_main_skid;
  logic              load_skid;

  assign in_ready = in_ready_reg;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is 0 here, so only the drain path exists.
          if (out_xfer) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      // Registered copy of "not full" for the state being entered.
      in_ready_reg <= (state_next != TWO);
      if (load_main_in) begin
        main_ctrl_reg <= in_ctrl;
        main_data_reg <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_reg <= skid_ctrl_reg;
        main_data_reg <= skid_data_reg;
      end
      if (load_skid) begin
        skid_ctrl_reg <= in_ctrl;
        skid_data_reg <= in_data;
      end
    end
  end
`else
  // Single-entry mode: accept whenever the register is empty or being drained.
  assign in_ready = (!out_valid || out_ready) && !reset;

  always_comb begin
    state_next   = state_reg;
    load_main_in = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          // An input transfer here implies the head is leaving in the same cycle.
          if (in_xfer) begin
            load_main_in = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= EMPTY;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main_in) begin
        main_ctrl_reg <= in_ctrl;
        main_data_reg <= in_data;
      end
    end
  end
`endif

  // Stall counter ignores flush: it reflects what the downstream saw before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

endmodule
